// File: rtl/shifter_arbiter.sv
// Two-port arbiter in front of one shared 32-bit barrel shifter.
// Round-robin grant, one operation in flight: IDLE -> EXEC -> RESP -> IDLE.

module barrel_shifter (
    input  logic [31:0] data_i,
    input  logic [2:0]  mode_i,
    input  logic [4:0]  count_i,
    output logic [31:0] result_o,
    output logic        illegal_o
);
    logic [63:0] rot;

    // Rotates shift a doubled word so count 0 needs no special case.
    always_comb begin
        rot       = {data_i, data_i};
        result_o  = '0;
        illegal_o = 1'b0;
        case (mode_i)
            3'b000: result_o = data_i << count_i;
            3'b001: result_o = data_i >> count_i;
            3'b010: begin
                rot      = {data_i, data_i} << count_i;
                result_o = rot[63:32];
            end
            3'b011: begin
                rot      = {data_i, data_i} >> count_i;
                result_o = rot[31:0];
            end
            3'b100:  result_o = $unsigned($signed(data_i) >>> count_i);
            default: illegal_o = 1'b1;
        endcase
    end
endmodule

module shifter_arbiter #(
    parameter int FIRST_GRANT = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0_valid,
    input  logic        i_req1_valid,
    output logic        o_req0_ready,
    output logic        o_req1_ready,
    input  logic [31:0] i_req0_data,
    input  logic [31:0] i_req1_data,
    input  logic [2:0]  i_req0_mode,
    input  logic [2:0]  i_req1_mode,
    input  logic [4:0]  i_req0_count,
    input  logic [4:0]  i_req1_count,
    output logic        o_rsp0_valid,
    output logic        o_rsp1_valid,
    input  logic        i_rsp0_ready,
    input  logic        i_rsp1_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic [1:0]  o_dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; ready never depends on a transfer completing later.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_vld_q, last_vld_d;
    logic        last_q, last_d;
    logic [31:0] op_data_q, op_data_d;
    logic [2:0]  op_mode_q, op_mode_d;
    logic [4:0]  op_cnt_q, op_cnt_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    logic        sel;
    logic        accept;
    logic        rsp_done;
    logic [31:0] sh_result;
    logic        sh_illegal;

    barrel_shifter u_shifter (
        .data_i   (op_data_q),
        .mode_i   (op_mode_q),
        .count_i  (op_cnt_q),
        .result_o (sh_result),
        .illegal_o(sh_illegal)
    );

    // sel is the requester that would win this cycle (1 = req1).
    always_comb begin
        sel = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            sel = last_vld_q ? ~last_q : (FIRST_GRANT != 0);
        end else begin
            sel = i_req1_valid;
        end
    end

    assign o_req0_ready = i_rst_n && (state_q == IDLE) && i_req0_valid && !sel;
    assign o_req1_ready = i_rst_n && (state_q == IDLE) && i_req1_valid && sel;
    assign accept       = o_req0_ready || o_req1_ready;

    assign o_rsp0_valid = (state_q == RESP) && !gnt_q;
    assign o_rsp1_valid = (state_q == RESP) && gnt_q;
    assign rsp_done     = gnt_q ? i_rsp1_ready : i_rsp0_ready;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_vld_d = last_vld_q;
        last_d     = last_q;
        op_data_d  = op_data_q;
        op_mode_d  = op_mode_q;
        op_cnt_d   = op_cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = EXEC;
                    gnt_d      = sel;
                    last_d     = sel;
                    last_vld_d = 1'b1;
                    op_data_d  = sel ? i_req1_data  : i_req0_data;
                    op_mode_d  = sel ? i_req1_mode  : i_req0_mode;
                    op_cnt_d   = sel ? i_req1_count : i_req0_count;
                end
            end
            EXEC: begin
                state_d    = RESP;
                rsp_data_d = sh_illegal ? 32'h0 : sh_result;
                rsp_err_d  = sh_illegal;
            end
            RESP: begin
                if (rsp_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_vld_q <= 1'b0;
            last_q     <= 1'b0;
            op_data_q  <= '0;
            op_mode_q  <= '0;
            op_cnt_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_vld_q <= last_vld_d;
            last_q     <= last_d;
            op_data_q  <= op_data_d;
            op_mode_q  <= op_mode_d;
            op_cnt_q   <= op_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_dbg_state = state_q;
endmodule
